// File: rtl/phasenoisepon_pkg.sv
// Shared command encodings and control FSM states for the phasenoisepon input front-end.
package phasenoisepon_pkg;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_TOGGLE = 2'b01;
  localparam logic [1:0] CMD_LOAD   = 2'b10;
  localparam logic [1:0] CMD_STEP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/phasenoisepon_sync_debounce.sv
// Two-flop synchroniser plus stable-cycle counter; stable flags the cycle the count reaches DEBOUNCE.
module phasenoisepon_sync_debounce #(
  parameter int W        = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         stable
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [W-1:0]  meta_p0;
  logic [W-1:0]  sync_p1;
  logic [W-1:0]  prev_p2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (sync_p1 != prev_p2)
      cnt_nxt = '0;
    else if (cnt != CW'(DEBOUNCE))
      cnt_nxt = cnt + 1'b1;
  end

  // Flag on the cycle the count gets there, so the FSM can act on the same edge.
  assign stable = (cnt_nxt == CW'(DEBOUNCE));
  assign dout   = sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
      cnt     <= '0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: rtl/phasenoisepon_ctl_frontend.sv
// Command front-end: sync/debounce ctl, decode run/load/step, prescale tick.
// Optional STEP command enabled by defining PHASENOISEPON_STEP_EN.
module phasenoisepon_ctl_frontend
  import phasenoisepon_pkg::*;
#(
  parameter int MAX_COUNT = 1000,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ctl,
  input  logic [3:0] data_in,
  output logic       run,
  output logic       tick,
  output logic       load,
  output logic [3:0] load_val
);

  localparam int             PW   = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [PW-1:0]  TERM = PW'(MAX_COUNT - 1);

  logic [1:0]    ctl_s;
  logic          stable;
  logic [1:0]    cmd;
  logic [3:0]    data_meta_p0;
  logic [3:0]    data_s_p1;
  state_t        state;
  state_t        state_nxt;
  logic          fire;
  logic [1:0]    cmd_q;
  logic          run_q;
  logic [3:0]    load_val_q;
  logic [PW-1:0] presc;
  logic          term;
  logic          step_tick;

  phasenoisepon_sync_debounce #(
    .W        (2),
    .DEBOUNCE (DEBOUNCE)
  ) u_ctl_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ctl),
    .dout   (ctl_s),
    .stable (stable)
  );

`ifdef PHASENOISEPON_STEP_EN
  assign cmd = ctl_s;
`else
  assign cmd = (ctl_s == CMD_STEP) ? CMD_NONE : ctl_s;
`endif

  // Load value is sampled only at acceptance, so it is synchronised but not debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta_p0 <= '0;
      data_s_p1    <= '0;
    end else begin
      data_meta_p0 <= data_in;
      data_s_p1    <= data_meta_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    unique case (state)
      ST_IDLE:    if (cmd != CMD_NONE) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (cmd == CMD_NONE) begin
          state_nxt = ST_IDLE;
        end else if (stable) begin
          state_nxt = ST_FIRE;
          fire      = 1'b1;
        end
      end
      ST_FIRE:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (cmd == CMD_NONE && stable) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Registered actions land on the FIRE cycle so load, load_val and run change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_q      <= CMD_NONE;
      run_q      <= 1'b0;
      load_val_q <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        cmd_q <= cmd;
        if (cmd == CMD_TOGGLE) run_q      <= ~run_q;
        if (cmd == CMD_LOAD)   load_val_q <= data_s_p1;
      end
    end
  end

  assign load      = (state == ST_FIRE) && (cmd_q == CMD_LOAD);
  assign step_tick = (state == ST_FIRE) && (cmd_q == CMD_STEP) && !run_q;
  assign term      = run_q && (presc == TERM);
  // A load on the terminal count suppresses that tick; the cleared prescaler restarts the period.
  assign tick      = (term && !load) || step_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc <= '0;
    else if (load)
      presc <= '0;
    else if (run_q)
      presc <= term ? '0 : presc + 1'b1;
  end

  assign run      = run_q;
  assign load_val = load_val_q;

endmodule

// File: tb/tb_phasenoisepon_ctl_frontend.sv
// Directed bench for phasenoisepon_ctl_frontend: press table plus prescaler/collision/reset sequences.
module tb_phasenoisepon_ctl_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ctl;
  logic [3:0] data_in;
  logic       run;
  logic       tick;
  logic       load;
  logic [3:0] load_val;

`ifdef PHASENOISEPON_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  phasenoisepon_ctl_frontend #(
    .MAX_COUNT (100),
    .DEBOUNCE  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ctl),
    .data_in  (data_in),
    .run      (run),
    .tick     (tick),
    .load     (load),
    .load_val (load_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] c;
    logic [3:0] d;
    int         hold;
    int         evt;
    int         loads;
    int         ticks;
    int         run_end;
    int         lv;
  } vec_t;

  vec_t vec[6];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tick_cnt = 0;
  int   load_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (tick) tick_cnt++;
      if (load) load_cnt++;
    end
  endtask

  task automatic wait_tick(output int n, input int limit);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      adv(1);
      if (tick) begin
        n = k;
        break;
      end
    end
  endtask

  int evt, r0, lc0, tc0, n, tc_ref;

  initial begin
    rst = 1'b1;
    ctl = 2'b00;
    data_in = 4'h0;

    vec[0] = '{2'b10, 4'd9, 10,  7, 1, 0, 0, 9};
    vec[1] = '{2'b01, 4'd0, 3,  -1, 0, 0, 0, 9};
    vec[2] = '{2'b11, 4'd0, 10, STEP_EN ? 7 : -1, 0, STEP_EN ? 1 : 0, 0, 9};
    vec[3] = '{2'b10, 4'd6, 4,  -1, 0, 0, 0, 9};
    vec[4] = '{2'b10, 4'd5, 5,   7, 1, 0, 0, 5};
    vec[5] = '{2'b01, 4'd0, 500, 7, 0, 5, 1, 5};

    adv(3);
    check("reset_run", run, 0);
    check("reset_tick", tick, 0);
    check("reset_load", load, 0);
    check("reset_load_val", load_val, 0);
    rst = 1'b0;
    adv(10);

    for (int i = 0; i < 6; i++) begin
      r0 = run; lc0 = load_cnt; tc0 = tick_cnt; evt = -1;
      ctl = vec[i].c; data_in = vec[i].d;
      for (int c = 1; c <= vec[i].hold + 10; c++) begin
        adv(1);
        if (evt < 0 && (load || tick || (run != r0[0]))) evt = c;
        if (c == vec[i].hold) ctl = 2'b00;
      end
      check($sformatf("row%0d_event_cycle", i), evt, vec[i].evt);
      check($sformatf("row%0d_loads", i), load_cnt - lc0, vec[i].loads);
      check($sformatf("row%0d_ticks", i), tick_cnt - tc0, vec[i].ticks);
      check($sformatf("row%0d_run", i), run, vec[i].run_end);
      check($sformatf("row%0d_load_val", i), load_val, vec[i].lv);
    end

    // Tick spacing while running.
    wait_tick(n, 200);
    check("first_tick_seen", (n > 0) ? 1 : 0, 1);
    wait_tick(n, 200);
    check("tick_gap_1", n, 100);
    wait_tick(n, 200);
    check("tick_gap_2", n, 100);

    // STEP while running adds no tick.
    tc_ref = tick_cnt;
    ctl = 2'b11;
    adv(10);
    ctl = 2'b00;
    wait_tick(n, 200);
    check("step_running_gap", n, 90);
    check("step_running_ticks", tick_cnt - tc_ref, 1);

    // Mid-count load restarts the period.
    adv(30);
    ctl = 2'b10; data_in = 4'd12;
    adv(7);
    check("midload_pulse", load, 1);
    check("midload_val", load_val, 12);
    adv(3);
    ctl = 2'b00;
    tc_ref = tick_cnt;
    wait_tick(n, 200);
    check("midload_next_tick", n, 97);
    check("midload_tick_count", tick_cnt - tc_ref, 1);

    // Load on terminal count: load wins, no tick that cycle.
    adv(93);
    ctl = 2'b10; data_in = 4'd7;
    adv(7);
    check("collide_load", load, 1);
    check("collide_tick", tick, 0);
    check("collide_load_val", load_val, 7);
    adv(3);
    ctl = 2'b00;
    wait_tick(n, 200);
    check("collide_next_tick", n, 97);

    // Stop coinciding with terminal count: tick still produced.
    adv(94);
    ctl = 2'b01;
    adv(6);
    check("stop_tc_tick", tick, 1);
    check("stop_tc_run_before", run, 1);
    adv(1);
    check("stop_tc_run_after", run, 0);
    adv(3);
    ctl = 2'b00;
    tc_ref = tick_cnt;
    adv(300);
    check("stopped_no_ticks", tick_cnt - tc_ref, 0);

    // Restart from wrapped prescaler.
    ctl = 2'b01;
    adv(7);
    check("restart_run", run, 1);
    adv(3);
    ctl = 2'b00;
    wait_tick(n, 200);
    check("restart_first_tick", n, 96);

    // Asynchronous reset mid-count.
    adv(20);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_run", run, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_load", load, 0);
    check("async_rst_load_val", load_val, 0);
    adv(2);
    rst = 1'b0;
    tc_ref = tick_cnt;
    adv(300);
    check("post_rst_idle_ticks", tick_cnt - tc_ref, 0);
    check("post_rst_idle_run", run, 0);

    // Command held through reset release acts as a new press.
    ctl = 2'b01;
    rst = 1'b1;
    adv(3);
    rst = 1'b0;
    adv(6);
    check("held_rst_run_early", run, 0);
    adv(1);
    check("held_rst_run_fire", run, 1);
    ctl = 2'b00;
    adv(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
